block_write_spi: RTL and testbench
==================================

Name: block_write_spi

Overview:
- SPI slave that owns one Nbit-wide write register at a fixed address (param_adr).
- Runs on the system clock and oversamples the external SPI pins (sclk, mosi, cs), which are asynchronous to clk.
- A frame is an 8-bit command byte followed by an Nbit data word; a matching write command updates the parallel output `out`.
- A matching read command returns the current register contents on miso.

Parameters:
- Nbit, 32, width of the data word and of `out`.
- param_adr, 1, 7-bit register address matched against command bits [6:0].

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from master, mode 0 (idle low, sample on rising edge, shift on falling edge).
- mosi  input  1  SPI data from master, MSB first.
- cs  input  1  SPI chip select, active low.
- miso  output  1  SPI data to master (read command only).
- out  output  Nbit  register contents; parallel output.

Behaviour:
- Reset (async, rst=1):
  - out=0, miso=0, state=IDLE, bit counter=0, shift registers=0, synchronizers cleared (sclk/mosi to 0, cs to 1).
- Input synchronization:
  - sclk, mosi and cs each pass through a 2-FF synchronizer.
  - sclk rise/fall are detected from the synchronized value versus its previous sample.
  - Requirement on the master: sclk high time and low time each ≥3 clk periods. The bench uses 5.
- Frame start/abort:
  - Synchronized cs high forces state=IDLE, counter=0 and miso=0. This applies in any state.
  - cs falling moves IDLE to CMD.
  - cs rising mid-frame aborts the frame; out is never updated by an aborted frame.
- CMD state:
  - Shift synchronized mosi into an 8-bit command register on each sclk rise, MSB first.
  - On the 8th rise, decode:
    - cmd[6:0]==param_adr[6:0] and cmd[7]=1 → WRITE.
    - cmd[6:0]==param_adr[6:0] and cmd[7]=0 → READ; load a read shift register with out; drive miso=MSB of out.
    - Otherwise → SKIP.
- WRITE state:
  - Shift mosi into an Nbit data shift register on each sclk rise; counter counts 0..Nbit.
  - On the Nbit-th rise, out<=received word (MSB = first data bit received), then go to DONE.
  - Latency: out changes on the 2nd clk edge after the synchronized sclk rise is detected, i.e. at most 4 clk cycles after the pin rises.
- READ state:
  - On each sclk fall, shift the read register left and drive miso=new MSB.
  - After Nbit bits, go to DONE with miso=0.
  - out is unchanged.
- SKIP / DONE:
  - Ignore all sclk edges until cs rises.
  - Extra bits beyond the frame length have no effect.
- Gaps:
  - Idle time of any length between the command byte and the data word is allowed while cs stays low; the state is held.
- mosi edges:
  - mosi may change at any time sclk is low; only the value sampled at a rise is used.
- Simultaneous events:
  - cs rise in the same cycle as the final sclk rise → abort wins; out is not updated.
  - rst overrides everything.
- Back-to-back frames:
  - A new cs falling edge starts a fresh CMD phase.
  - Each completed write overwrites out.

Test Plan:
- Reset, then cs low, send 0x81, then 0xDEEDBEEF (half period 5 clk), cs high → out=0xDEEDBEEF within 4 clk of the 40th sclk rise; 0 before that.
- Send 0x82 + 0x12345678 → out stays at its previous value (0xDEEDBEEF).
- Send 0x01 after the first test → miso presents 0xDEEDBEEF MSB first, stable at each of sclk rises 9..40; out unchanged.
- Send 0x81 + 16 bits of 0xA5A5…, then raise cs → out unchanged. The next full frame 0x81 + 0x12345678 → out=0x12345678.
- Send 0x81 + 0xCAFEF00D + 8 extra bits with cs still low → out=0xCAFEF00D; the extra bits are ignored.
- Assert rst mid-frame (during data) → out=0 immediately without a clk edge; the next full write frame works normally.

Source files
------------

// File: rtl/block_write_spi_if.sv
// block_write_spi_if: SPI pins (sclk, mosi, cs in; miso out) plus the parallel register output `out`.
interface block_write_spi_if #(parameter int Nbit = 32);
  logic sclk, mosi, cs, miso;
  logic [Nbit-1:0] out;
  modport master(output sclk, mosi, cs, input miso, out);
  modport slave(input sclk, mosi, cs, output miso, out);
endinterface

// File: rtl/block_write_spi.sv
// block_write_spi: oversampled mode-0 SPI slave with one Nbit write register at param_adr; ports clk, rst (async high), bus (sclk/mosi/cs in, miso/out out).
module block_write_spi #(
  parameter int Nbit = 32,
  parameter logic [6:0] param_adr = 7'd1
) (
  input logic clk,
  input logic rst,
  block_write_spi_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, SKIP, DONE} state_t;
  localparam int CW = $clog2(Nbit + 1);
  state_t r_state, w_next;
  logic [1:0] r_sclk_s, r_mosi_s, r_cs_s;
  logic r_sclk_d, r_miso;
  logic [CW-1:0] r_cnt;
  logic [6:0] r_cmd;
  logic [Nbit-2:0] r_data;
  logic [Nbit-1:0] r_rd, r_out;
  logic w_sclk, w_mosi, w_cs, w_rise, w_fall, w_hit, w_last_cmd, w_last_bit;
  logic w_cmd_sh, w_wr_sh, w_wr_done, w_rd_load, w_rd_sh, w_cnt_clr, w_cnt_inc;
  logic [7:0] w_cmd;
  assign w_sclk = r_sclk_s[1];
  assign w_mosi = r_mosi_s[1];
  assign w_cs = r_cs_s[1];
  assign w_rise = w_sclk & ~r_sclk_d;
  assign w_fall = ~w_sclk & r_sclk_d;
  assign w_cmd = {r_cmd, w_mosi};
  assign w_hit = w_cmd[6:0] == param_adr;
  assign w_last_cmd = r_cnt == CW'(7);
  assign w_last_bit = r_cnt == CW'(Nbit - 1);
  assign bus.miso = r_miso;
  assign bus.out = r_out;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sclk_s <= '0;
      r_mosi_s <= '0;
      r_cs_s <= 2'b11;
      r_sclk_d <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], bus.sclk};
      r_mosi_s <= {r_mosi_s[0], bus.mosi};
      r_cs_s <= {r_cs_s[0], bus.cs};
      r_sclk_d <= r_sclk_s[1];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_cs) w_next = IDLE;
    else
      case (r_state)
        IDLE: w_next = CMD;
        CMD: if (w_rise && w_last_cmd) w_next = !w_hit ? SKIP : w_cmd[7] ? WRITE : READ;
        WRITE, READ: if (w_rise && w_last_bit) w_next = DONE;
        default: w_next = r_state;
      endcase
  end
  always_comb begin
    w_cmd_sh = !w_cs && r_state == CMD && w_rise;
    w_wr_sh = !w_cs && r_state == WRITE && w_rise;
    w_wr_done = r_state == WRITE && w_next == DONE;
    w_rd_load = r_state == CMD && w_next == READ;
    // the fall right after the command byte must not shift: the first data rise samples the MSB
    w_rd_sh = !w_cs && r_state == READ && w_fall && r_cnt != '0;
    w_cnt_clr = w_next != r_state;
    w_cnt_inc = w_rise && (r_state == CMD || r_state == WRITE || r_state == READ);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_cmd <= '0;
      r_data <= '0;
      r_rd <= '0;
      r_out <= '0;
      r_miso <= 1'b0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : w_cnt_inc ? r_cnt + 1'b1 : r_cnt;
      if (w_cmd_sh) r_cmd <= w_cmd[6:0];
      if (w_wr_sh) r_data <= {r_data[Nbit-3:0], w_mosi};
      if (w_wr_done) r_out <= {r_data, w_mosi};
      r_rd <= w_rd_load ? r_out : w_rd_sh ? r_rd << 1 : r_rd;
      r_miso <= w_next != READ ? 1'b0 : w_rd_load ? r_out[Nbit-1] : w_rd_sh ? r_rd[Nbit-2] : r_miso;
    end
endmodule

// File: tb/tb_block_write_spi.sv
// tb_block_write_spi: randomized and directed frame-level checks of block_write_spi against a register model.
module tb_block_write_spi;
  localparam int N = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [N-1:0] model_out;
  logic [63:0] cap;
  block_write_spi_if #(.Nbit(N)) bus();
  block_write_spi #(.Nbit(N), .param_adr(7'd1)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic sbit(input logic b, output logic m);
    bus.mosi = b;
    wclk(5);
    m = bus.miso;
    bus.sclk = 1'b1;
    wclk(5);
    bus.sclk = 1'b0;
  endtask
  task automatic cs_low;
    bus.cs = 1'b0;
    wclk(5);
  endtask
  task automatic cs_high;
    wclk(5);
    bus.cs = 1'b1;
    wclk(6);
  endtask
  task automatic frame(input logic [7:0] cmd, input logic [63:0] dat, input int nd, input int gap);
    logic m;
    cap = '0;
    cs_low();
    for (int i = 0; i < 8; i++) sbit(cmd[7-i], m);
    if (gap > 0) wclk(gap);
    for (int i = 0; i < nd; i++) begin
      sbit(dat[63-i], m);
      cap[63-i] = m;
    end
    cs_high();
  endtask
  task automatic test_reset;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.cs = 1'b1;
    #1 rst = 1'b1;
    wclk(3);
    tests++;
    if (bus.out !== '0) begin fails++; $display("FAIL reset_out got=%h exp=0", bus.out); end
    tests++;
    if (bus.miso !== 1'b0) begin fails++; $display("FAIL reset_miso got=%b exp=0", bus.miso); end
    rst = 1'b0;
    wclk(3);
    model_out = '0;
  endtask
  task automatic test_write;
    logic m;
    logic [39:0] bits;
    bits = {8'h81, 32'hDEEDBEEF};
    cs_low();
    for (int i = 0; i < 39; i++) sbit(bits[39-i], m);
    tests++;
    if (bus.out !== '0) begin fails++; $display("FAIL write_before_last got=%h exp=0", bus.out); end
    bus.mosi = bits[0];
    wclk(5);
    bus.sclk = 1'b1;
    wclk(1);
    tests++;
    if (bus.out !== '0) begin fails++; $display("FAIL write_early got=%h exp=0", bus.out); end
    wclk(3);
    tests++;
    if (bus.out !== 32'hDEEDBEEF) begin fails++; $display("FAIL write_latency got=%h exp=deedbeef", bus.out); end
    wclk(4);
    bus.sclk = 1'b0;
    cs_high();
    model_out = 32'hDEEDBEEF;
    tests++;
    if (bus.out !== model_out) begin fails++; $display("FAIL write_hold got=%h exp=%h", bus.out, model_out); end
  endtask
  task automatic test_wrong_addr;
    frame(8'h82, {32'h12345678, 32'h0}, 32, 0);
    tests++;
    if (bus.out !== model_out) begin fails++; $display("FAIL wrong_addr got=%h exp=%h", bus.out, model_out); end
  endtask
  task automatic test_read;
    frame(8'h01, 64'h0, 32, 0);
    tests++;
    if (cap[63:32] !== model_out) begin fails++; $display("FAIL read_miso got=%h exp=%h", cap[63:32], model_out); end
    tests++;
    if (bus.out !== model_out) begin fails++; $display("FAIL read_out got=%h exp=%h", bus.out, model_out); end
    tests++;
    if (bus.miso !== 1'b0) begin fails++; $display("FAIL read_miso_idle got=%b exp=0", bus.miso); end
  endtask
  task automatic test_abort;
    frame(8'h81, {16'hA5A5, 48'h0}, 16, 0);
    tests++;
    if (bus.out !== model_out) begin fails++; $display("FAIL abort got=%h exp=%h", bus.out, model_out); end
    frame(8'h81, {32'h12345678, 32'h0}, 32, 0);
    model_out = 32'h12345678;
    tests++;
    if (bus.out !== model_out) begin fails++; $display("FAIL after_abort got=%h exp=%h", bus.out, model_out); end
  endtask
  task automatic test_extra_bits;
    frame(8'h81, {32'hCAFEF00D, 8'hFF, 24'h0}, 40, 0);
    model_out = 32'hCAFEF00D;
    tests++;
    if (bus.out !== model_out) begin fails++; $display("FAIL extra_bits got=%h exp=%h", bus.out, model_out); end
  endtask
  task automatic test_rst_mid;
    logic m;
    logic [17:0] bits;
    logic [31:0] w;
    bits = {8'h81, 10'h2AB};
    cs_low();
    for (int i = 0; i < 18; i++) sbit(bits[17-i], m);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.out !== '0) begin fails++; $display("FAIL rst_mid_async got=%h exp=0", bus.out); end
    model_out = '0;
    bus.cs = 1'b1;
    wclk(2);
    rst = 1'b0;
    wclk(3);
    w = $urandom;
    frame(8'h81, {w, 32'h0}, 32, 0);
    model_out = w;
    tests++;
    if (bus.out !== model_out) begin fails++; $display("FAIL rst_mid_next got=%h exp=%h", bus.out, model_out); end
  endtask
  task automatic test_random;
    logic [7:0] cmd;
    logic [63:0] dat;
    logic [N-1:0] old;
    int kind, nd, gap;
    for (int it = 0; it < 10; it++) begin
      kind = int'($urandom_range(0, 3));
      cmd = kind == 0 || kind == 3 ? 8'h81 : kind == 1 ? 8'h01 : 8'($urandom);
      dat = {$urandom, $urandom};
      nd = kind == 3 ? int'($urandom_range(1, 31)) : 32 + int'($urandom_range(0, 4));
      gap = int'($urandom_range(0, 12));
      old = model_out;
      frame(cmd, dat, nd, gap);
      if (cmd[6:0] == 7'd1 && nd >= 32) begin
        if (cmd[7]) model_out = dat[63:32];
        else begin
          tests++;
          if (cap[63:32] !== old) begin fails++; $display("FAIL rand_read[%0d] got=%h exp=%h", it, cap[63:32], old); end
        end
      end
      tests++;
      if (bus.out !== model_out) begin fails++; $display("FAIL rand_out[%0d] cmd=%h nd=%0d got=%h exp=%h", it, cmd, nd, bus.out, model_out); end
    end
  endtask
  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_abort();
    test_extra_bits();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
